// File: rtl/multicycle_ctrl_if.sv
// Shared control-path types and the controller <-> datapath bundle.
// The controller owns the master modport; the datapath (or a bench) owns slave.
package multicycle_ctrl_pkg;

   typedef enum logic [1:0] {
      SRC_RS1  = 2'd0,
      SRC_PC   = 2'd1,
      SRC_ZERO = 2'd2
   } alu_srcA_t;

   typedef enum logic [1:0] {
      SRC_RS2 = 2'd0,
      SRC_IMM = 2'd1,
      SRC_4   = 2'd2
   } alu_srcB_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_AND  = 4'd7,
      ALU_BEQ  = 4'd8,
      ALU_BNE  = 4'd9,
      ALU_BLT  = 4'd10,
      ALU_BGE  = 4'd11,
      ALU_BLTU = 4'd12,
      ALU_BGEU = 4'd13
   } alu_op_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [31:0] instr;
   logic        mem_ready;
   logic        br_taken;
   alu_srcA_t   alu_srcA;
   alu_srcB_t   alu_srcB;
   alu_op_t     alu_op;
   logic        pc_we;
   logic        pc_src;
   logic        ir_we;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        retire;
   logic        trap;

   modport master (
      input  instr, mem_ready, br_taken,
      output alu_srcA, alu_srcB, alu_op, pc_we, pc_src, ir_we,
             mem_req, mem_we, addr_sel, rf_we, wb_sel, retire, trap
   );

   modport slave (
      output instr, mem_ready, br_taken,
      input  alu_srcA, alu_srcB, alu_op, pc_we, pc_src, ir_we,
             mem_req, mem_we, addr_sel, rf_we, wb_sel, retire, trap
   );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM. Outputs are decoded from state and the
// latched instruction; only the handshake-qualified enables look at mem_ready
// and br_taken. rst forces all outputs to their idle values combinationally.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_JAL    = 4'd10,
      S_JALR   = 4'd11,
      S_UPPER  = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_wait_cnt;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_r_legal;
   logic       w_i_legal;
   logic       w_b_legal;
   logic       w_in_mem_state;
   logic       w_mem_wait;
   logic       w_timeout;
   logic       w_unused;

   alu_srcA_t  w_alu_srcA;
   alu_srcB_t  w_alu_srcB;
   alu_op_t    w_alu_op;
   logic       w_pc_we;
   logic       w_pc_src;
   logic       w_ir_we;
   logic       w_mem_req;
   logic       w_mem_we;
   logic       w_addr_sel;
   logic       w_rf_we;
   logic [1:0] w_wb_sel;
   logic       w_retire;
   logic       w_trap;

   assign w_opcode = bus.instr[6:0];
   assign w_funct3 = bus.instr[14:12];
   assign w_funct7 = bus.instr[31:25];
   // Register numbers and immediates belong to the datapath.
   assign w_unused = ^{bus.instr[24:15], bus.instr[11:7]};

   // Only funct7 = 0 (or 0100000 for SUB) is implemented; SLTU and SRA trap.
   assign w_r_legal = ((w_funct7 == 7'b0000000) && (w_funct3 != 3'b011)) ||
                      ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000));
   // Immediate shifts carry funct7 in the immediate field; SRAI and SLTIU trap.
   assign w_i_legal = ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) ?
                      (w_funct7 == 7'b0000000) : (w_funct3 != 3'b011);
   assign w_b_legal = (w_funct3[2:1] != 2'b01);

   assign w_in_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                           (r_state == S_MEM_WR);
   assign w_mem_wait     = w_in_mem_state && !bus.mem_ready;
   // The cycle that would be the MEM_TIMEOUT-th consecutive wait ends the wait.
   assign w_timeout      = (MEM_TIMEOUT > 0) && w_mem_wait &&
                           (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

   function automatic alu_op_t f_arith_op(input logic [2:0] funct3, input logic sub);
      alu_op_t op;
      case (funct3)
         3'b000:  op = sub ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic alu_op_t f_branch_op(input logic [2:0] funct3);
      alu_op_t op;
      case (funct3)
         3'b000:  op = ALU_BEQ;
         3'b001:  op = ALU_BNE;
         3'b100:  op = ALU_BLT;
         3'b101:  op = ALU_BGE;
         3'b110:  op = ALU_BLTU;
         3'b111:  op = ALU_BGEU;
         default: op = ALU_BEQ;
      endcase
      return op;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next_state;
   end

   // Consecutive memory-wait counter; any non-waiting cycle clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (w_mem_wait) begin
         if (r_wait_cnt != {CW{1'b1}}) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: begin
            if (w_timeout)          w_next_state = S_TRAP;
            else if (bus.mem_ready) w_next_state = S_DECODE;
         end
         S_DECODE: begin
            case (w_opcode)
               OP_R:               w_next_state = w_r_legal ? S_EXEC_R : S_TRAP;
               OP_I:               w_next_state = w_i_legal ? S_EXEC_I : S_TRAP;
               OP_LOAD, OP_STORE:  w_next_state = S_ADDR;
               OP_BRANCH:          w_next_state = w_b_legal ? S_BRANCH : S_TRAP;
               OP_JAL:             w_next_state = S_JAL;
               OP_JALR:            w_next_state = (w_funct3 == 3'b000) ? S_JALR : S_TRAP;
               OP_LUI, OP_AUIPC:   w_next_state = S_UPPER;
               default:            w_next_state = S_TRAP;
            endcase
         end
         S_EXEC_R, S_EXEC_I: w_next_state = S_WB_ALU;
         S_ADDR: begin
            if (w_funct3 != 3'b010)       w_next_state = S_TRAP;
            else if (w_opcode == OP_STORE) w_next_state = S_MEM_WR;
            else                           w_next_state = S_MEM_RD;
         end
         S_MEM_RD: begin
            if (w_timeout)          w_next_state = S_TRAP;
            else if (bus.mem_ready) w_next_state = S_WB_MEM;
         end
         S_MEM_WR: begin
            if (w_timeout)          w_next_state = S_TRAP;
            else if (bus.mem_ready) w_next_state = S_FETCH;
         end
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_UPPER: w_next_state = S_FETCH;
         S_JALR:  w_next_state = S_JAL;
         S_TRAP:  w_next_state = S_TRAP;
         default: w_next_state = S_TRAP;
      endcase
   end

   // Output decode; held at idle values while rst is high.
   always_comb begin
      w_alu_srcA = SRC_RS1;
      w_alu_srcB = SRC_RS2;
      w_alu_op   = ALU_ADD;
      w_pc_we    = 1'b0;
      w_pc_src   = 1'b0;
      w_ir_we    = 1'b0;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
      w_addr_sel = 1'b0;
      w_rf_we    = 1'b0;
      w_wb_sel   = 2'd0;
      w_retire   = 1'b0;
      w_trap     = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               w_mem_req  = 1'b1;
               w_alu_srcA = SRC_PC;
               w_alu_srcB = SRC_4;
               // A timeout cycle has mem_ready low, so nothing is committed.
               w_ir_we    = bus.mem_ready;
               w_pc_we    = bus.mem_ready;
            end
            S_DECODE: begin
               w_alu_srcA = SRC_PC;
               w_alu_srcB = SRC_IMM;
            end
            S_EXEC_R: w_alu_op = f_arith_op(w_funct3, w_funct7[5]);
            S_EXEC_I: begin
               w_alu_srcB = SRC_IMM;
               w_alu_op   = f_arith_op(w_funct3, 1'b0);
            end
            S_ADDR, S_JALR: w_alu_srcB = SRC_IMM;
            S_MEM_RD: begin
               w_mem_req  = 1'b1;
               w_addr_sel = 1'b1;
            end
            S_MEM_WR: begin
               w_mem_req  = 1'b1;
               w_addr_sel = 1'b1;
               w_mem_we   = 1'b1;
               w_retire   = bus.mem_ready;
            end
            S_WB_ALU: begin
               w_rf_we  = 1'b1;
               w_retire = 1'b1;
            end
            S_WB_MEM: begin
               w_rf_we  = 1'b1;
               w_wb_sel = 2'd1;
               w_retire = 1'b1;
            end
            S_BRANCH: begin
               w_alu_op = f_branch_op(w_funct3);
               w_pc_we  = bus.br_taken;
               w_pc_src = 1'b1;
               w_retire = 1'b1;
            end
            S_JAL: begin
               w_alu_srcA = SRC_PC;
               w_alu_srcB = SRC_4;
               w_rf_we    = 1'b1;
               w_wb_sel   = 2'd2;
               w_pc_we    = 1'b1;
               w_pc_src   = 1'b1;
               w_retire   = 1'b1;
            end
            S_UPPER: begin
               w_alu_srcA = (w_opcode == OP_LUI) ? SRC_ZERO : SRC_PC;
               w_alu_srcB = SRC_IMM;
               w_rf_we    = 1'b1;
               w_wb_sel   = 2'd2;
               w_retire   = 1'b1;
            end
            S_TRAP:  w_trap = 1'b1;
            default: w_trap = 1'b1;
         endcase
      end
   end

   assign bus.alu_srcA = w_alu_srcA;
   assign bus.alu_srcB = w_alu_srcB;
   assign bus.alu_op   = w_alu_op;
   assign bus.pc_we    = w_pc_we;
   assign bus.pc_src   = w_pc_src;
   assign bus.ir_we    = w_ir_we;
   assign bus.mem_req  = w_mem_req;
   assign bus.mem_we   = w_mem_we;
   assign bus.addr_sel = w_addr_sel;
   assign bus.rf_we    = w_rf_we;
   assign bus.wb_sel   = w_wb_sel;
   assign bus.retire   = w_retire;
   assign bus.trap     = w_trap;

endmodule
